avalon_pio_ext: RTL and testbench
=================================

// Module: avalon_pio_ext
// PURPOSE
//  Parametrised Avalon-MM slave PIO for the Nios II SoC top level.
//  Replaces the bare LED export with a single peripheral that provides:
//   - an LED output register with per-bit hardware blink;
//   - debounced KEY inputs with edge capture and a maskable IRQ.
//  Sits in FPGA fabric beside the SoC; KEY/LEDR connect straight to board pins.
// PARAMETERS
//  LED_W        8       LED output width (1..32)
//  KEY_W        2       KEY input width (1..32)
//  DEB_CYCLES   500000  consecutive stable cycles before a key state is accepted (10 ms @ 50 MHz)
//  BLINK_PERIOD 12500000 cycles per blink half-period (250 ms @ 50 MHz)
//  EDGE_MODE    0       edge capture: 0=falling (press, keys active-low), 1=rising, 2=both
// PORTS
//  clk        in   1      system clock (MAX10_CLK1_50 domain)
//  reset      in   1      synchronous, active-high reset
//  address    in   3      Avalon word address
//  read       in   1      Avalon read strobe
//  write      in   1      Avalon write strobe
//  writedata  in   32     Avalon write data
//  readdata   out  32     Avalon read data, valid 1 cycle after read
//  irq        out  1      level interrupt to Nios II
//  key_in     in   KEY_W  raw board keys, asynchronous, active-low
//  led_out    out  LED_W  LED pins, active-high
// BEHAVIOUR
//  Register map (word addresses; unused bits read 0; writes to RO/undefined addresses ignored):
//   0 LED_DATA   RW [LED_W-1:0]
//   1 KEY_STATE  RO [KEY_W-1:0] debounced key levels
//   2 EDGE_CAP   RW1C [KEY_W-1:0]
//   3 IRQ_MASK   RW [KEY_W-1:0]
//   4 BLINK_MASK RW [LED_W-1:0]
//   5-7 read 0
//  Reset values:
//   - LED_DATA, EDGE_CAP, IRQ_MASK, BLINK_MASK = 0.
//   - KEY_STATE and synchroniser FFs = all 1 (keys released).
//   - readdata = 0, irq = 0, led_out = 0.
//   - Blink counter and blink phase = 0; debounce counters = 0.
//  Read: fixed latency 1. readdata is registered from address on the read cycle; it holds its value otherwise.
//  Write: takes effect at the clock edge of the write cycle. Read and write in the same cycle are both honoured:
//   readdata returns the pre-write value.
//  Key input path, per key:
//   - 2-FF synchroniser.
//   - Counter clears whenever the synced input equals KEY_STATE; otherwise it increments.
//   - When the counter reaches DEB_CYCLES-1, KEY_STATE takes the synced value and the counter clears.
//   - Glitches shorter than DEB_CYCLES never change KEY_STATE.
//  Edge capture:
//   - An edge bit sets on a KEY_STATE transition that matches EDGE_MODE.
//   - It stays set until software writes 1 to that bit.
//   - A set event and a W1C on the same bit in the same cycle: the set wins.
//  irq = |(EDGE_CAP & IRQ_MASK), registered: asserts 1 cycle after the bit sets or the mask is enabled,
//   and deasserts 1 cycle after the clear.
//  Blink:
//   - Counter runs 0..BLINK_PERIOD-1 and wraps; the phase toggles on each wrap.
//   - led_out (registered) = LED_DATA ^ (BLINK_MASK & {LED_W{phase}}).
//   - A write to LED_DATA is visible on led_out 1 cycle after the write edge.
//  Reset asserted mid-debounce or mid-blink: all state returns to reset values on the next edge, with no
//   spurious edge or IRQ. Counter widths are $clog2 of their limits; no overflow is possible.
// TESTING (DEB_CYCLES=4, BLINK_PERIOD=8, LED_W=8, KEY_W=2, EDGE_MODE=0)
//  1 reset, then read addr 0-7 -> readdata 0,0x3,0,0,0,0,0,0; irq=0; led_out=0x00
//  2 write LED_DATA=0xA5 -> led_out=0xA5 one cycle after the write; read addr0 -> 0xA5
//  3 key_in[0] low for 3 cycles, then high -> KEY_STATE stays 0x3, EDGE_CAP stays 0
//  4 IRQ_MASK=0x1, key_in[0] held low -> KEY_STATE=0x2 after 2 sync + 4 stable cycles; EDGE_CAP=0x1;
//     irq=1 next cycle; write EDGE_CAP=0x1 -> irq=0 one cycle later
//  5 BLINK_MASK=0x0F, LED_DATA=0xA5 -> led_out alternates 0xA5/0xAA every 8 cycles
//  6 W1C on EDGE_CAP[1] in the same cycle as a new key1 press edge -> bit stays 1;
//     reset asserted mid-debounce -> no edge and no irq afterwards

Source files
------------

// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext: Avalon-MM PIO with blinking LED register and debounced, edge-captured keys with IRQ
module avalon_pio_ext #(
   parameter int LED_W        = 8,
   parameter int KEY_W        = 2,
   parameter int DEB_CYCLES   = 500000,
   parameter int BLINK_PERIOD = 12500000,
   parameter int EDGE_MODE    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [KEY_W-1:0] key_in,
   output logic [LED_W-1:0] led_out
);
   localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
   localparam int BW = BLINK_PERIOD > 1 ? $clog2(BLINK_PERIOD) : 1;
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIOD - 1);
   logic [KEY_W-1:0] sync1, sync2, key_state, upd, ev, edge_cap, irq_mask;
   logic [DW-1:0]    deb_cnt [KEY_W];
   logic [LED_W-1:0] led_data, blink_mask;
   logic [BW-1:0]    blink_cnt;
   logic             phase, blink_wrap;
   logic [31:0]      rd_mux;
   always_comb begin
      upd = '0;
      for (int k = 0; k < KEY_W; k++)
         upd[k] = (sync2[k] != key_state[k]) && (deb_cnt[k] == DEB_MAX);
      ev = EDGE_MODE == 0 ? (upd & key_state) : EDGE_MODE == 1 ? (upd & ~key_state) : upd;
      blink_wrap = blink_cnt == BLINK_MAX;
      rd_mux = address == 3'd0 ? 32'(led_data) :
               address == 3'd1 ? 32'(key_state) :
               address == 3'd2 ? 32'(edge_cap) :
               address == 3'd3 ? 32'(irq_mask) :
               address == 3'd4 ? 32'(blink_mask) : 32'd0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= '1;
         sync2      <= '1;
         key_state  <= '1;
         deb_cnt    <= '{default: '0};
         edge_cap   <= '0;
         irq_mask   <= '0;
         led_data   <= '0;
         blink_mask <= '0;
         blink_cnt  <= '0;
         phase      <= 1'b0;
         readdata   <= '0;
         irq        <= 1'b0;
         led_out    <= '0;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
         for (int k = 0; k < KEY_W; k++)
            deb_cnt[k] <= (sync2[k] == key_state[k] || upd[k]) ? '0 : deb_cnt[k] + 1'b1;
         key_state <= key_state ^ upd;
         // a same-cycle capture event overrides the software clear
         edge_cap <= (edge_cap & ~((write && address == 3'd2) ? writedata[KEY_W-1:0] : '0)) | ev;
         if (write && address == 3'd0) led_data <= writedata[LED_W-1:0];
         if (write && address == 3'd3) irq_mask <= writedata[KEY_W-1:0];
         if (write && address == 3'd4) blink_mask <= writedata[LED_W-1:0];
         if (read) readdata <= rd_mux;
         irq       <= |(edge_cap & irq_mask);
         blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
         phase     <= phase ^ blink_wrap;
         led_out   <= led_data ^ (blink_mask & {LED_W{phase}});
      end
   end
endmodule

// File: tb/tb_avalon_pio_ext.sv
// tb_avalon_pio_ext: directed register-table and multi-cycle key/blink/irq checks
module tb_avalon_pio_ext;
   logic        clk = 1'b0, reset = 1'b1, read = 1'b0, write = 1'b0;
   logic [2:0]  address = '0;
   logic [31:0] writedata = '0, readdata, rv;
   logic        irq;
   logic [1:0]  key_in = 2'b11;
   logic [7:0]  led_out, p;
   int          checks = 0, errors = 0;
   typedef struct {
      bit          wr;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [28];

   avalon_pio_ext #(.LED_W(8), .KEY_W(2), .DEB_CYCLES(4), .BLINK_PERIOD(8), .EDGE_MODE(0)) dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata), .irq(irq), .key_in(key_in), .led_out(led_out));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      tick();
      write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a; read = 1'b1;
      tick();
      read = 1'b0;
      d = readdata;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      vecs = '{
         '{0, 3'd0, 0, 32'h0},   '{0, 3'd1, 0, 32'h3},   '{0, 3'd2, 0, 32'h0},   '{0, 3'd3, 0, 32'h0},
         '{0, 3'd4, 0, 32'h0},   '{0, 3'd5, 0, 32'h0},   '{0, 3'd6, 0, 32'h0},   '{0, 3'd7, 0, 32'h0},
         '{1, 3'd0, 32'hA5, 0},  '{0, 3'd0, 0, 32'hA5},  '{1, 3'd3, 32'hFF, 0},  '{0, 3'd3, 0, 32'h3},
         '{1, 3'd4, 32'h1FF, 0}, '{0, 3'd4, 0, 32'hFF},  '{1, 3'd1, 32'h0, 0},   '{0, 3'd1, 0, 32'h3},
         '{1, 3'd5, 32'hDEAD, 0},'{0, 3'd5, 0, 32'h0},   '{1, 3'd2, 32'h3, 0},   '{0, 3'd2, 0, 32'h0},
         '{1, 3'd3, 32'h0, 0},   '{0, 3'd3, 0, 32'h0},   '{1, 3'd4, 32'h0, 0},   '{0, 3'd4, 0, 32'h0},
         '{1, 3'd0, 32'h0, 0},   '{0, 3'd0, 0, 32'h0},   '{0, 3'd7, 0, 32'h0},   '{0, 3'd1, 0, 32'h3}};
      tick();
      tick();
      reset = 1'b0;
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("reset_led", {24'b0, led_out}, 32'h0);
      for (int i = 0; i < 28; i++) begin
         if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
         else begin
            rd(vecs[i].addr, rv);
            check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rv, vecs[i].exp);
         end
      end
      // LED write visibility latency
      wr(3'd0, 32'hA5);
      check("led_same_edge", {24'b0, led_out}, 32'h0);
      tick();
      check("led_next_edge", {24'b0, led_out}, 32'hA5);
      // simultaneous read and write returns the old value
      address = 3'd0; writedata = 32'h22; read = 1'b1; write = 1'b1;
      tick();
      read = 1'b0; write = 1'b0;
      check("rw_same_cycle_old", readdata, 32'hA5);
      rd(3'd0, rv);
      check("rw_same_cycle_new", rv, 32'h22);
      wr(3'd0, 32'hA5);
      // short glitch is rejected
      key_in = 2'b10;
      repeat (3) tick();
      key_in = 2'b11;
      repeat (10) tick();
      rd(3'd1, rv);
      check("glitch_key_state", rv, 32'h3);
      rd(3'd2, rv);
      check("glitch_edge_cap", rv, 32'h0);
      // full press: sync(2) + debounce(4) edges
      wr(3'd3, 32'h1);
      key_in = 2'b10;
      repeat (4) tick();
      rd(3'd1, rv);
      check("press_state_edge5", rv, 32'h3);
      rd(3'd1, rv);
      check("press_state_edge6", rv, 32'h3);
      check("press_irq_edge6", {31'b0, irq}, 32'h0);
      rd(3'd2, rv);
      check("press_edge_cap", rv, 32'h1);
      check("press_irq_edge7", {31'b0, irq}, 32'h1);
      rd(3'd1, rv);
      check("press_state_after", rv, 32'h2);
      wr(3'd2, 32'h1);
      check("w1c_irq_same_edge", {31'b0, irq}, 32'h1);
      tick();
      check("w1c_irq_after", {31'b0, irq}, 32'h0);
      rd(3'd2, rv);
      check("w1c_edge_cap", rv, 32'h0);
      // blink alternation
      wr(3'd4, 32'h0F);
      tick();
      tick();
      p = led_out;
      check("blink_base_valid", {31'b0, (p == 8'hA5 || p == 8'hAA)}, 32'h1);
      begin
         int n = 0;
         while (led_out === p && n < 20) begin
            tick();
            n++;
         end
         check("blink_change_seen", {31'b0, (n < 20)}, 32'h1);
      end
      for (int i = 0; i < 24; i++) begin
         check($sformatf("blink_cycle%0d", i), {24'b0, led_out}, {24'b0, ((i / 8) % 2 == 0) ? (p ^ 8'h0F) : p});
         tick();
      end
      wr(3'd4, 32'h0);
      // set beats W1C on the same bit in the same cycle
      wr(3'd3, 32'h3);
      key_in = 2'b00;
      repeat (5) tick();
      wr(3'd2, 32'h2);
      rd(3'd2, rv);
      check("set_beats_w1c", rv, 32'h2);
      check("set_beats_w1c_irq", {31'b0, irq}, 32'h1);
      wr(3'd2, 32'h3);
      tick();
      check("clear_key1_irq", {31'b0, irq}, 32'h0);
      // release: rising transitions are not captured in falling mode
      key_in = 2'b11;
      repeat (10) tick();
      rd(3'd2, rv);
      check("release_no_capture", rv, 32'h0);
      rd(3'd1, rv);
      check("release_state", rv, 32'h3);
      // reset in the middle of a debounce and a blink
      wr(3'd4, 32'hFF);
      key_in = 2'b01;
      repeat (3) tick();
      key_in = 2'b11;
      do_reset();
      check("midreset_readdata", readdata, 32'h0);
      check("midreset_led", {24'b0, led_out}, 32'h0);
      repeat (10) tick();
      check("midreset_irq", {31'b0, irq}, 32'h0);
      check("midreset_led_later", {24'b0, led_out}, 32'h0);
      rd(3'd2, rv);
      check("midreset_edge_cap", rv, 32'h0);
      rd(3'd1, rv);
      check("midreset_key_state", rv, 32'h3);
      rd(3'd3, rv);
      check("midreset_irq_mask", rv, 32'h0);
      rd(3'd4, rv);
      check("midreset_blink_mask", rv, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
